// File: rtl/trap_unit.sv
`default_nettype none
// ==========================================================================
// trap_unit : M/S/U privileged CSR file, exception/interrupt entry, xRET
// rev 1.0
// ==========================================================================
module trap_unit #(
  parameter int XLEN     = 64,
  parameter bit VECTORED = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] data1,
  input  logic [4:0]      cause,
  input  logic [11:0]     tval,
  input  logic            exc_valid,
  input  logic [3:0]      exc_code,
  input  logic [XLEN-1:0] exc_tval,
  input  logic [2:0]      irq,
  output logic [XLEN-1:0] csr_data,
  output logic            op_csr,
  output logic [XLEN-1:0] satp,
  output logic [1:0]      priv,
  output logic            trap_en,
  output logic [XLEN-1:0] trap_pc
);

  localparam logic [4:0] SYSOP_ECALL = 5'd1;
  localparam logic [4:0] SYSOP_RET   = 5'd2;
  localparam logic [4:0] SYSOP_CSR_W = 5'd3;
  localparam logic [4:0] SYSOP_CSR_S = 5'd4;
  localparam logic [4:0] SYSOP_CSR_C = 5'd5;

  localparam logic [1:0] PRIV_U = 2'd0;
  localparam logic [1:0] PRIV_S = 2'd1;
  localparam logic [1:0] PRIV_M = 2'd3;

  localparam int ST_SIE  = 1;
  localparam int ST_MIE  = 3;
  localparam int ST_SPIE = 5;
  localparam int ST_MPIE = 7;
  localparam int ST_SPP  = 8;
  localparam int ST_MPP  = 11;

  localparam logic [XLEN-1:0] MSTATUS_MASK = XLEN'(32'h0000_19AA);
  localparam logic [XLEN-1:0] SSTATUS_MASK = XLEN'(32'h0000_0122);
  localparam logic [XLEN-1:0] MIP_RO       = XLEN'(32'h0000_0888);
  localparam logic [XLEN-1:0] IRQ_FLAG     = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [1:0]      MXL          = (XLEN == 64) ? 2'b10 : 2'b01;
  // RV{32,64} I M A S U
  localparam logic [XLEN-1:0] MISA_VAL     = {MXL, {(XLEN-23){1'b0}}, 21'h14_1101};

  logic [XLEN-1:0] mstatus_q, mstatus_d;
  logic [XLEN-1:0] medeleg_q, medeleg_d;
  logic [XLEN-1:0] mie_q, mie_d;
  logic [XLEN-1:0] mip_q, mip_d;
  logic [XLEN-1:0] mtvec_q, mtvec_d;
  logic [XLEN-1:0] mscratch_q, mscratch_d;
  logic [XLEN-1:0] mepc_q, mepc_d;
  logic [XLEN-1:0] mcause_q, mcause_d;
  logic [XLEN-1:0] mtval_q, mtval_d;
  logic [XLEN-1:0] stvec_q, stvec_d;
  logic [XLEN-1:0] sscratch_q, sscratch_d;
  logic [XLEN-1:0] sepc_q, sepc_d;
  logic [XLEN-1:0] scause_q, scause_d;
  logic [XLEN-1:0] stval_q, stval_d;
  logic [XLEN-1:0] satp_q, satp_d;
  logic [1:0]      priv_q, priv_d;
  logic            trap_en_q, trap_en_d;
  logic [XLEN-1:0] trap_pc_q, trap_pc_d;

  logic [XLEN-1:0] mip_rd, pending, csr_rdata, wval;
  logic            is_csr, csr_hit, csr_legal, csr_illegal;
  logic            is_ret, is_mret, is_sret, ret_legal, ret_illegal, is_ecall;
  logic            irq_take, take_exc, to_s;
  logic [3:0]      irq_code, trap_code;
  logic [XLEN-1:0] trap_tv;
  logic [15:0]     medeleg_lo;

  function automatic logic [XLEN-1:0] legal_mstatus(input logic [XLEN-1:0] v);
    logic [XLEN-1:0] m;
    m = v & MSTATUS_MASK;
    if (m[ST_MPP+1:ST_MPP] == 2'b10) m[ST_MPP+1:ST_MPP] = PRIV_U;
    return m;
  endfunction

  function automatic logic [XLEN-1:0] legal_tvec(input logic [XLEN-1:0] v);
    logic [XLEN-1:0] t;
    t    = v;
    t[1] = 1'b0;
    if (!VECTORED) t[0] = 1'b0;
    return t;
  endfunction

  // Read mux and legality decode
  always_comb begin
    mip_rd     = (mip_q & ~MIP_RO) | XLEN'({irq[2], 3'b000, irq[1], 3'b000, irq[0], 3'b000});
    pending    = mip_rd & mie_q;
    csr_hit    = 1'b1;
    csr_rdata  = '0;
    case (tval)
      12'h300: csr_rdata = mstatus_q;
      12'h301: csr_rdata = MISA_VAL;
      12'h302: csr_rdata = medeleg_q;
      12'h304: csr_rdata = mie_q;
      12'h305: csr_rdata = mtvec_q;
      12'h340: csr_rdata = mscratch_q;
      12'h341: csr_rdata = mepc_q;
      12'h342: csr_rdata = mcause_q;
      12'h343: csr_rdata = mtval_q;
      12'h344: csr_rdata = mip_rd;
      12'h100: csr_rdata = mstatus_q & SSTATUS_MASK;
      12'h105: csr_rdata = stvec_q;
      12'h140: csr_rdata = sscratch_q;
      12'h141: csr_rdata = sepc_q;
      12'h142: csr_rdata = scause_q;
      12'h143: csr_rdata = stval_q;
      12'h180: csr_rdata = satp_q;
      default: csr_hit   = 1'b0;
    endcase
    is_csr      = (cause == SYSOP_CSR_W) || (cause == SYSOP_CSR_S) || (cause == SYSOP_CSR_C);
    // every CSR op counts as a write, so read-only space is always illegal
    csr_legal   = is_csr && csr_hit && (tval[9:8] <= priv_q) && (tval[11:10] != 2'b11);
    csr_illegal = is_csr && !csr_legal;
    is_ret      = (cause == SYSOP_RET);
    is_mret     = (tval == 12'h302);
    is_sret     = (tval == 12'h102);
    ret_legal   = is_ret && ((is_mret && priv_q == PRIV_M) || (is_sret && priv_q != PRIV_U));
    ret_illegal = is_ret && !ret_legal;
    is_ecall    = (cause == SYSOP_ECALL);
    irq_code    = 4'd0;
    if (pending[11])     irq_code = 4'd11;
    else if (pending[3]) irq_code = 4'd3;
    else if (pending[7]) irq_code = 4'd7;
    irq_take    = (pending[11] | pending[3] | pending[7]) &&
                  ((priv_q != PRIV_M) || mstatus_q[ST_MIE]);
    case (cause)
      SYSOP_CSR_S: wval = csr_rdata | data1;
      SYSOP_CSR_C: wval = csr_rdata & ~data1;
      default:     wval = data1;
    endcase
  end

  assign csr_data = csr_legal ? csr_rdata : '0;
  assign op_csr   = is_csr;
  assign satp     = satp_q;
  assign priv     = priv_q;
  assign trap_en  = trap_en_q;
  assign trap_pc  = trap_pc_q;

  // Event arbitration and next state; only the winning event updates state
  always_comb begin
    mstatus_d  = mstatus_q;
    medeleg_d  = medeleg_q;
    mie_d      = mie_q;
    mip_d      = mip_q;
    mtvec_d    = mtvec_q;
    mscratch_d = mscratch_q;
    mepc_d     = mepc_q;
    mcause_d   = mcause_q;
    mtval_d    = mtval_q;
    stvec_d    = stvec_q;
    sscratch_d = sscratch_q;
    sepc_d     = sepc_q;
    scause_d   = scause_q;
    stval_d    = stval_q;
    satp_d     = satp_q;
    priv_d     = priv_q;
    trap_en_d  = 1'b0;
    trap_pc_d  = trap_pc_q;

    take_exc  = 1'b1;
    trap_code = 4'd0;
    trap_tv   = '0;
    if (exc_valid) begin
      trap_code = exc_code;
      trap_tv   = exc_tval;
    end else if (csr_illegal || ret_illegal) begin
      trap_code = 4'd2;
    end else if (is_ecall) begin
      trap_code = 4'd8 + {2'b00, priv_q};
    end else begin
      take_exc = 1'b0;
    end
    medeleg_lo = medeleg_q[15:0];
    to_s       = (priv_q != PRIV_M) && medeleg_lo[trap_code];

    if (take_exc) begin
      trap_en_d = 1'b1;
      if (to_s) begin
        sepc_d              = pc & ~XLEN'(1);
        scause_d            = XLEN'(trap_code);
        stval_d             = trap_tv;
        mstatus_d[ST_SPIE]  = mstatus_q[ST_SIE];
        mstatus_d[ST_SIE]   = 1'b0;
        mstatus_d[ST_SPP]   = priv_q[0];
        priv_d              = PRIV_S;
        trap_pc_d           = stvec_q & ~XLEN'(3);
      end else begin
        mepc_d                     = pc & ~XLEN'(1);
        mcause_d                   = XLEN'(trap_code);
        mtval_d                    = trap_tv;
        mstatus_d[ST_MPIE]         = mstatus_q[ST_MIE];
        mstatus_d[ST_MIE]          = 1'b0;
        mstatus_d[ST_MPP+1:ST_MPP] = priv_q;
        priv_d                     = PRIV_M;
        trap_pc_d                  = mtvec_q & ~XLEN'(3);
      end
    end else if (ret_legal && is_mret) begin
      trap_en_d                  = 1'b1;
      mstatus_d[ST_MIE]          = mstatus_q[ST_MPIE];
      mstatus_d[ST_MPIE]         = 1'b1;
      priv_d                     = mstatus_q[ST_MPP+1:ST_MPP];
      mstatus_d[ST_MPP+1:ST_MPP] = PRIV_U;
      trap_pc_d                  = mepc_q;
    end else if (ret_legal) begin
      trap_en_d          = 1'b1;
      mstatus_d[ST_SIE]  = mstatus_q[ST_SPIE];
      mstatus_d[ST_SPIE] = 1'b1;
      priv_d             = {1'b0, mstatus_q[ST_SPP]};
      mstatus_d[ST_SPP]  = 1'b0;
      trap_pc_d          = sepc_q;
    end else if (irq_take) begin
      trap_en_d                  = 1'b1;
      mepc_d                     = pc & ~XLEN'(1);
      mcause_d                   = IRQ_FLAG | XLEN'(irq_code);
      mtval_d                    = '0;
      mstatus_d[ST_MPIE]         = mstatus_q[ST_MIE];
      mstatus_d[ST_MIE]          = 1'b0;
      mstatus_d[ST_MPP+1:ST_MPP] = priv_q;
      priv_d                     = PRIV_M;
      trap_pc_d                  = mtvec_q & ~XLEN'(3);
      if (VECTORED && mtvec_q[0]) trap_pc_d = (mtvec_q & ~XLEN'(3)) + XLEN'({irq_code, 2'b00});
    end else if (csr_legal) begin
      case (tval)
        12'h300: mstatus_d  = legal_mstatus(wval);
        12'h302: medeleg_d  = wval;
        12'h304: mie_d      = wval;
        12'h305: mtvec_d    = legal_tvec(wval);
        12'h340: mscratch_d = wval;
        12'h341: mepc_d     = wval & ~XLEN'(1);
        12'h342: mcause_d   = wval;
        12'h343: mtval_d    = wval;
        12'h344: mip_d      = wval & ~MIP_RO;
        12'h100: mstatus_d  = (mstatus_q & ~SSTATUS_MASK) | (wval & SSTATUS_MASK);
        12'h105: stvec_d    = legal_tvec(wval);
        12'h140: sscratch_d = wval;
        12'h141: sepc_d     = wval & ~XLEN'(1);
        12'h142: scause_d   = wval;
        12'h143: stval_d    = wval;
        12'h180: satp_d     = wval;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mstatus_q  <= '0;
      medeleg_q  <= '0;
      mie_q      <= '0;
      mip_q      <= '0;
      mtvec_q    <= '0;
      mscratch_q <= '0;
      mepc_q     <= '0;
      mcause_q   <= '0;
      mtval_q    <= '0;
      stvec_q    <= '0;
      sscratch_q <= '0;
      sepc_q     <= '0;
      scause_q   <= '0;
      stval_q    <= '0;
      satp_q     <= '0;
      priv_q     <= PRIV_M;
      trap_en_q  <= 1'b0;
      trap_pc_q  <= '0;
    end else begin
      mstatus_q  <= mstatus_d;
      medeleg_q  <= medeleg_d;
      mie_q      <= mie_d;
      mip_q      <= mip_d;
      mtvec_q    <= mtvec_d;
      mscratch_q <= mscratch_d;
      mepc_q     <= mepc_d;
      mcause_q   <= mcause_d;
      mtval_q    <= mtval_d;
      stvec_q    <= stvec_d;
      sscratch_q <= sscratch_d;
      sepc_q     <= sepc_d;
      scause_q   <= scause_d;
      stval_q    <= stval_d;
      satp_q     <= satp_d;
      priv_q     <= priv_d;
      trap_en_q  <= trap_en_d;
      trap_pc_q  <= trap_pc_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_trap_unit.sv
`default_nettype none
// ==========================================================================
// tb_trap_unit : directed self-checking bench; trap redirects via scoreboard
// rev 1.0
// ==========================================================================
module tb_trap_unit;
  localparam int XLEN = 64;
  localparam logic [4:0] NONE = 5'd0, ECALL = 5'd1, RET = 5'd2;
  localparam logic [4:0] CW = 5'd3, CS = 5'd4, CC = 5'd5;
  localparam logic [XLEN-1:0] MISA64 = 64'h8000_0000_0014_1101;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [XLEN-1:0] pc = '0, data1 = '0, exc_tval = '0;
  logic [4:0]      cause = NONE;
  logic [11:0]     tval = '0;
  logic            exc_valid = 1'b0;
  logic [3:0]      exc_code = '0;
  logic [2:0]      irq = '0;
  logic [XLEN-1:0] csr_data, satp, trap_pc;
  logic            op_csr, trap_en;
  logic [1:0]      priv;

  logic [XLEN-1:0] exp_q[$];
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  trap_unit #(.XLEN(XLEN), .VECTORED(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .pc(pc), .data1(data1), .cause(cause), .tval(tval),
    .exc_valid(exc_valid), .exc_code(exc_code), .exc_tval(exc_tval), .irq(irq),
    .csr_data(csr_data), .op_csr(op_csr), .satp(satp), .priv(priv),
    .trap_en(trap_en), .trap_pc(trap_pc)
  );

  task automatic chk(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    cause = NONE; exc_valid = 1'b0; data1 = '0; tval = '0;
  endtask

  // One clock; a queued redirect must appear now, otherwise trap_en must be low
  task automatic tick(input string tag);
    logic [XLEN-1:0] e;
    @(posedge clk); #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk({tag, "_en"}, XLEN'(trap_en), XLEN'(1));
      chk({tag, "_pc"}, trap_pc, e);
    end else begin
      chk({tag, "_idle"}, XLEN'(trap_en), '0);
    end
  endtask

  task automatic csr(input logic [4:0] op, input logic [11:0] a, input logic [XLEN-1:0] d,
                     input logic [XLEN-1:0] old, input bit illegal, input logic [XLEN-1:0] tgt,
                     input string tag);
    cause = op; tval = a; data1 = d; exc_valid = 1'b0;
    #1;
    chk({tag, "_op"}, XLEN'(op_csr), XLEN'(1));
    chk({tag, "_rd"}, csr_data, illegal ? '0 : old);
    if (illegal) exp_q.push_back(tgt);
    tick(tag);
    idle();
  endtask

  task automatic rd(input logic [11:0] a, input logic [XLEN-1:0] v, input string tag);
    csr(CS, a, '0, v, 1'b0, '0, tag);
  endtask

  task automatic sysop(input logic [4:0] op, input logic [11:0] f, input logic [XLEN-1:0] p,
                       input logic [XLEN-1:0] tgt, input string tag);
    cause = op; tval = f; pc = p;
    exp_q.push_back(tgt);
    tick(tag);
    idle();
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_en", XLEN'(trap_en), '0);
    chk("rst_pc", trap_pc, '0);
    chk("rst_priv", XLEN'(priv), XLEN'(3));
    chk("rst_satp", satp, '0);
    @(negedge clk); rst_n = 1'b1;
    tick("rel");
    rd(12'h301, MISA64, "misa_rst");
    rd(12'h300, '0, "mstatus_rst");

    // ECALL from M
    csr(CW, 12'h305, 64'h8000_0000, '0, 1'b0, '0, "w_mtvec");
    sysop(ECALL, 12'h000, 64'h1234_0000, 64'h8000_0000, "ecall_m");
    chk("ecall_m_priv", XLEN'(priv), XLEN'(3));
    rd(12'h342, 64'd11, "mcause_11");
    rd(12'h341, 64'h1234_0000, "mepc_1");
    rd(12'h300, 64'h1800, "mstatus_mpp");
    rd(12'h343, '0, "mtval_0");

    // mret to U, then delegated ECALL to S, then sret back to U
    csr(CW, 12'h302, 64'h100, '0, 1'b0, '0, "w_medeleg");
    csr(CW, 12'h105, 64'h100, '0, 1'b0, '0, "w_stvec");
    csr(CW, 12'h341, 64'h2000, 64'h1234_0000, 1'b0, '0, "w_mepc");
    csr(CW, 12'h300, '0, 64'h1800, 1'b0, '0, "w_mstatus0");
    sysop(RET, 12'h302, 64'h1500, 64'h2000, "mret");
    chk("mret_priv", XLEN'(priv), '0);
    sysop(ECALL, 12'h000, 64'h3000, 64'h100, "ecall_u");
    chk("ecall_u_priv", XLEN'(priv), XLEN'(1));
    chk("mcause_kept", dut.mcause_q, 64'd11);
    rd(12'h142, 64'd8, "scause_8");
    rd(12'h141, 64'h3000, "sepc");
    rd(12'h100, '0, "sstatus_0");
    sysop(RET, 12'h102, 64'h3100, 64'h3000, "sret");
    chk("sret_priv", XLEN'(priv), '0);

    // illegal CSR from U, then read-only misa write in M
    pc = 64'h6000;
    csr(CS, 12'h340, 64'h55, '0, 1'b1, 64'h8000_0000, "ill_mscratch");
    chk("ill_priv", XLEN'(priv), XLEN'(3));
    rd(12'h342, 64'd2, "mcause_2");
    rd(12'h343, '0, "mtval_ill");
    rd(12'h341, 64'h6000, "mepc_ill");
    rd(12'h340, '0, "mscratch_kept");
    rd(12'h300, 64'h20, "mstatus_ill");
    csr(CW, 12'h301, '0, MISA64, 1'b0, '0, "w_misa");
    rd(12'h301, MISA64, "misa_kept");

    // vectored machine timer interrupt
    csr(CW, 12'h305, 64'h1001, 64'h8000_0000, 1'b0, '0, "w_mtvec_v");
    csr(CW, 12'h304, 64'h80, '0, 1'b0, '0, "w_mie");
    csr(CW, 12'h300, 64'h8, 64'h20, 1'b0, '0, "w_mstatus_mie");
    pc = 64'h4000; irq = 3'b010;
    exp_q.push_back(64'h101C);
    tick("mti");
    irq = 3'b000;
    chk("mti_priv", XLEN'(priv), XLEN'(3));
    rd(12'h342, 64'h8000_0000_0000_0007, "mcause_irq");
    rd(12'h341, 64'h4000, "mepc_irq");
    rd(12'h300, 64'h1880, "mstatus_irq");
    irq = 3'b101;
    rd(12'h344, 64'h808, "mip_mirror");
    irq = 3'b000;

    // exception beats interrupts in the same cycle; MIE=0 then blocks them
    csr(CW, 12'h304, 64'h888, 64'h80, 1'b0, '0, "w_mie_all");
    csr(CW, 12'h300, 64'h8, 64'h1880, 1'b0, '0, "w_mstatus_mie2");
    irq = 3'b111; exc_valid = 1'b1; exc_code = 4'd5; exc_tval = 64'hDEAD; pc = 64'h5000;
    exp_q.push_back(64'h1000);
    tick("exc5");
    idle();
    tick("irq_blocked");
    rd(12'h342, 64'd5, "mcause_5");
    rd(12'h343, 64'hDEAD, "mtval_5");
    rd(12'h300, 64'h1880, "mstatus_exc");
    irq = 3'b000;

    // satp export and back-to-back RMW
    cause = CW; tval = 12'h180; data1 = 64'h8000_0000_0001_2345;
    #1;
    chk("satp_pre", satp, '0);
    tick("w_satp");
    idle();
    chk("satp_out", satp, 64'h8000_0000_0001_2345);
    rd(12'h180, 64'h8000_0000_0001_2345, "satp_rd");
    csr(CW, 12'h340, 64'hA, '0, 1'b0, '0, "w_mscratch");
    csr(CS, 12'h340, 64'h5, 64'hA, 1'b0, '0, "s_mscratch");
    rd(12'h340, 64'hF, "mscratch_f");

    // reset in the middle of an ECALL cycle
    cause = ECALL; pc = 64'h7000;
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_satp", satp, '0);
    chk("mid_rst_priv", XLEN'(priv), XLEN'(3));
    idle();
    @(posedge clk); #1;
    chk("mid_rst_en", XLEN'(trap_en), '0);
    @(negedge clk); rst_n = 1'b1;
    tick("post_rst1");
    tick("post_rst2");
    rd(12'h340, '0, "mscratch_rst");

    chk("sb_empty", XLEN'(exp_q.size()), '0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
